// File: rtl/eth_phy_reset_seq.sv
// eth_phy_reset_seq: TX/RX reset sequencer for NUM_CH 10GBASE-R channels sharing one TX PLL.
// Optional macro ETH_PHY_RSTSEQ_HIBER_RELOCK_EN re-sequences a lane after sustained high BER.
module eth_phy_reset_seq #(
    parameter int NUM_CH    = 4,
    parameter int T_ANALOG  = 70,
    parameter int T_DIGITAL = 20,
    parameter int T_LTD     = 4000,
    parameter int T_HIBER   = 1000
) (
    input  logic                  reconfig_clk,
    input  logic                  reconfig_reset_n,
    input  logic                  pll_locked,
    input  logic [NUM_CH-1:0]     tx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_is_lockedtodata,
    input  logic [NUM_CH-1:0]     rx_enh_highber,
    input  logic [NUM_CH-1:0]     rx_reset_req,
    output logic [NUM_CH-1:0]     tx_analogreset,
    output logic [NUM_CH-1:0]     tx_digitalreset,
    output logic [NUM_CH-1:0]     rx_analogreset,
    output logic [NUM_CH-1:0]     rx_digitalreset,
    output logic                  tx_ready,
    output logic [NUM_CH-1:0]     rx_ready,
    output logic [8*NUM_CH-1:0]   relock_cnt
);

    localparam int T_MAX_A = (T_ANALOG > T_DIGITAL) ? T_ANALOG : T_DIGITAL;
    localparam int T_MAX_B = (T_LTD > T_HIBER) ? T_LTD : T_HIBER;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] ANA_LAST = CW'(T_ANALOG - 1);
    localparam logic [CW-1:0] DIG_LAST = CW'(T_DIGITAL - 1);
    localparam logic [CW-1:0] LTD_LAST = CW'(T_LTD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] TX_ARST  = 2'd0;
    localparam logic [1:0] TX_WAIT  = 2'd1;
    localparam logic [1:0] TX_DRST  = 2'd2;
    localparam logic [1:0] TX_READY = 2'd3;

    localparam logic [2:0] RX_ARST     = 3'd0;
    localparam logic [2:0] RX_WAIT_CAL = 3'd1;
    localparam logic [2:0] RX_WAIT_LTD = 3'd2;
    localparam logic [2:0] RX_DRST     = 3'd3;
    localparam logic [2:0] RX_READY    = 3'd4;

    logic [1:0]    tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic          pll_s1, pll_s2;

    // Lock is re-observed through the full synchroniser after every analog reset,
    // so a stale "locked" from before the reset can never release the digital reset.
    always_ff @(posedge reconfig_clk) begin
        if (!reconfig_reset_n || tx_state == TX_ARST) begin
            pll_s1 <= 1'b0;
            pll_s2 <= 1'b0;
        end else begin
            pll_s1 <= pll_locked;
            pll_s2 <= pll_s1;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        case (tx_state)
            TX_ARST: begin
                if (tx_cnt == ANA_LAST) begin
                    tx_state_nxt = TX_WAIT;
                    tx_cnt_nxt   = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            TX_WAIT: begin
                if (pll_s2 && tx_cal_busy == '0) begin
                    tx_state_nxt = TX_DRST;
                    tx_cnt_nxt   = '0;
                end
            end
            TX_DRST: begin
                if (!pll_s2) begin
                    tx_state_nxt = TX_ARST;
                    tx_cnt_nxt   = '0;
                end else if (tx_cnt == DIG_LAST) begin
                    tx_state_nxt = TX_READY;
                    tx_cnt_nxt   = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            TX_READY: begin
                if (!pll_s2) begin
                    tx_state_nxt = TX_ARST;
                    tx_cnt_nxt   = '0;
                end
            end
            default: begin
                tx_state_nxt = TX_ARST;
                tx_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge reconfig_clk) begin
        if (!reconfig_reset_n) begin
            tx_state        <= TX_ARST;
            tx_cnt          <= '0;
            tx_analogreset  <= '1;
            tx_digitalreset <= '1;
            tx_ready        <= 1'b0;
        end else begin
            tx_state        <= tx_state_nxt;
            tx_cnt          <= tx_cnt_nxt;
            tx_analogreset  <= {NUM_CH{tx_state == TX_ARST}};
            tx_digitalreset <= {NUM_CH{tx_state != TX_READY}};
            tx_ready        <= (tx_state == TX_READY);
        end
    end

`ifndef ETH_PHY_RSTSEQ_HIBER_RELOCK_EN
    logic unused_highber;
    assign unused_highber = ^rx_enh_highber;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic [2:0]    rx_state, rx_state_nxt;
        logic [CW-1:0] rx_cnt, rx_cnt_nxt;
        logic [7:0]    relock_q, relock_nxt, relock_inc;
        logic          ltd_s1, ltd_s2, hiber_fire;
        logic          ana_q, dig_q, rdy_q;

        assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

        always_ff @(posedge reconfig_clk) begin
            if (!reconfig_reset_n) begin
                ltd_s1 <= 1'b0;
                ltd_s2 <= 1'b0;
            end else begin
                ltd_s1 <= rx_is_lockedtodata[g];
                ltd_s2 <= ltd_s1;
            end
        end

`ifdef ETH_PHY_RSTSEQ_HIBER_RELOCK_EN
        localparam logic [CW-1:0] HIB_LAST = CW'(T_HIBER - 1);
        logic          hb_s1, hb_s2;
        logic [CW-1:0] hb_cnt;

        assign hiber_fire = (rx_state == RX_READY) && hb_s2 && (hb_cnt == HIB_LAST);

        always_ff @(posedge reconfig_clk) begin
            if (!reconfig_reset_n) begin
                hb_s1  <= 1'b0;
                hb_s2  <= 1'b0;
                hb_cnt <= '0;
            end else begin
                hb_s1  <= rx_enh_highber[g];
                hb_s2  <= hb_s1;
                hb_cnt <= (rx_state == RX_READY && hb_s2) ? hb_cnt + CNT_ONE : '0;
            end
        end
`else
        assign hiber_fire = 1'b0;
`endif

        // Priority: soft request, then lock loss, then high-BER, then normal progression.
        always_comb begin
            rx_state_nxt = rx_state;
            rx_cnt_nxt   = rx_cnt;
            relock_nxt   = relock_q;
            if (rx_reset_req[g]) begin
                rx_state_nxt = RX_ARST;
                rx_cnt_nxt   = '0;
            end else if ((rx_state == RX_DRST || rx_state == RX_READY) && !ltd_s2) begin
                rx_state_nxt = RX_WAIT_LTD;
                rx_cnt_nxt   = '0;
                relock_nxt   = relock_inc;
            end else if (hiber_fire) begin
                rx_state_nxt = RX_ARST;
                rx_cnt_nxt   = '0;
                relock_nxt   = relock_inc;
            end else begin
                case (rx_state)
                    RX_ARST: begin
                        if (rx_cnt == ANA_LAST) begin
                            rx_state_nxt = RX_WAIT_CAL;
                            rx_cnt_nxt   = '0;
                        end else begin
                            rx_cnt_nxt = rx_cnt + CNT_ONE;
                        end
                    end
                    RX_WAIT_CAL: begin
                        if (!rx_cal_busy[g]) begin
                            rx_state_nxt = RX_WAIT_LTD;
                            rx_cnt_nxt   = '0;
                        end
                    end
                    RX_WAIT_LTD: begin
                        if (!ltd_s2) begin
                            rx_cnt_nxt = '0;
                        end else if (rx_cnt == LTD_LAST) begin
                            rx_state_nxt = RX_DRST;
                            rx_cnt_nxt   = '0;
                        end else begin
                            rx_cnt_nxt = rx_cnt + CNT_ONE;
                        end
                    end
                    RX_DRST: begin
                        if (rx_cnt == DIG_LAST) begin
                            rx_state_nxt = RX_READY;
                            rx_cnt_nxt   = '0;
                        end else begin
                            rx_cnt_nxt = rx_cnt + CNT_ONE;
                        end
                    end
                    RX_READY: begin
                        rx_state_nxt = RX_READY;
                    end
                    default: begin
                        rx_state_nxt = RX_ARST;
                        rx_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge reconfig_clk) begin
            if (!reconfig_reset_n) begin
                rx_state <= RX_ARST;
                rx_cnt   <= '0;
                relock_q <= '0;
                ana_q    <= 1'b1;
                dig_q    <= 1'b1;
                rdy_q    <= 1'b0;
            end else begin
                rx_state <= rx_state_nxt;
                rx_cnt   <= rx_cnt_nxt;
                relock_q <= relock_nxt;
                ana_q    <= (rx_state == RX_ARST);
                dig_q    <= (rx_state != RX_READY);
                rdy_q    <= (rx_state == RX_READY);
            end
        end

        assign rx_analogreset[g]     = ana_q;
        assign rx_digitalreset[g]    = dig_q;
        assign rx_ready[g]           = rdy_q;
        assign relock_cnt[8*g +: 8]  = relock_q;
    end

endmodule

// File: tb/tb_eth_phy_reset_seq.sv
// Self-checking bench for eth_phy_reset_seq: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a phase/duration model.
module tb_eth_phy_reset_seq;

    localparam int NCH = 2;
    localparam int TA  = 4;
    localparam int TD  = 3;
    localparam int TL  = 8;
    localparam int TH  = 5;

`ifdef ETH_PHY_RSTSEQ_HIBER_RELOCK_EN
    localparam bit HIBER_ON = 1'b1;
`else
    localparam bit HIBER_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reconfig_reset_n;
    logic             pll_locked;
    logic [NCH-1:0]   tx_cal_busy, rx_cal_busy, rx_is_lockedtodata, rx_enh_highber, rx_reset_req;
    logic [NCH-1:0]   tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, rx_ready;
    logic             tx_ready;
    logic [8*NCH-1:0] relock_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eth_phy_reset_seq #(
        .NUM_CH(NCH), .T_ANALOG(TA), .T_DIGITAL(TD), .T_LTD(TL), .T_HIBER(TH)
    ) dut (
        .reconfig_clk(clk),
        .reconfig_reset_n(reconfig_reset_n),
        .pll_locked(pll_locked),
        .tx_cal_busy(tx_cal_busy),
        .rx_cal_busy(rx_cal_busy),
        .rx_is_lockedtodata(rx_is_lockedtodata),
        .rx_enh_highber(rx_enh_highber),
        .rx_reset_req(rx_reset_req),
        .tx_analogreset(tx_analogreset),
        .tx_digitalreset(tx_digitalreset),
        .rx_analogreset(rx_analogreset),
        .rx_digitalreset(rx_digitalreset),
        .tx_ready(tx_ready),
        .rx_ready(rx_ready),
        .relock_cnt(relock_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Phases with elapsed-cycle ages; synchronised inputs are the raw input two edges back.
    localparam int P_ANA = 0, P_CAL = 1, P_LOCK = 2, P_DIG = 3, P_RDY = 4;

    int             tx_ph, tx_age;
    bit             pll_q1, pll_q2;
    int             rx_ph [NCH];
    int             rx_age[NCH];
    int             hb_run[NCH];
    int             relocks[NCH];
    bit             ltd_q1[NCH], ltd_q2[NCH], hb_q1[NCH], hb_q2[NCH];
    logic [NCH-1:0] exp_tx_ana, exp_tx_dig, exp_rx_ana, exp_rx_dig, exp_rx_rdy;
    logic           exp_tx_rdy;
    logic [8*NCH-1:0] exp_relock;
    bit             model_valid = 1'b0;

    always @(posedge clk) begin
        bit pll_seen, ltd_seen, hb_seen, hb_fire;
        int run_nxt;
        if (!reconfig_reset_n) begin
            tx_ph = P_ANA; tx_age = 0; pll_q1 = 0; pll_q2 = 0;
            for (int i = 0; i < NCH; i++) begin
                rx_ph[i] = P_ANA; rx_age[i] = 0; hb_run[i] = 0; relocks[i] = 0;
                ltd_q1[i] = 0; ltd_q2[i] = 0; hb_q1[i] = 0; hb_q2[i] = 0;
            end
            exp_tx_ana = '1; exp_tx_dig = '1; exp_tx_rdy = 1'b0;
            exp_rx_ana = '1; exp_rx_dig = '1; exp_rx_rdy = '0;
        end else begin
            exp_tx_ana = {NCH{tx_ph == P_ANA}};
            exp_tx_dig = {NCH{tx_ph != P_RDY}};
            exp_tx_rdy = (tx_ph == P_RDY);
            for (int i = 0; i < NCH; i++) begin
                exp_rx_ana[i] = (rx_ph[i] == P_ANA);
                exp_rx_dig[i] = (rx_ph[i] != P_RDY);
                exp_rx_rdy[i] = (rx_ph[i] == P_RDY);
            end
            pll_seen = pll_q2;
            if (tx_ph == P_ANA) begin
                pll_q1 = 0; pll_q2 = 0;
            end else begin
                pll_q2 = pll_q1; pll_q1 = pll_locked;
            end
            case (tx_ph)
                P_ANA: begin tx_age++; if (tx_age == TA) begin tx_ph = P_CAL; tx_age = 0; end end
                P_CAL: if (pll_seen && tx_cal_busy == '0) begin tx_ph = P_DIG; tx_age = 0; end
                P_DIG: begin
                    if (!pll_seen) begin tx_ph = P_ANA; tx_age = 0; end
                    else begin tx_age++; if (tx_age == TD) begin tx_ph = P_RDY; tx_age = 0; end end
                end
                default: if (!pll_seen) begin tx_ph = P_ANA; tx_age = 0; end
            endcase
            for (int i = 0; i < NCH; i++) begin
                ltd_seen = ltd_q2[i];
                hb_seen  = hb_q2[i];
                ltd_q2[i] = ltd_q1[i]; ltd_q1[i] = rx_is_lockedtodata[i];
                hb_q2[i]  = hb_q1[i];  hb_q1[i]  = rx_enh_highber[i];
                run_nxt = (rx_ph[i] == P_RDY && hb_seen) ? hb_run[i] + 1 : 0;
                hb_fire = HIBER_ON && run_nxt == TH;
                if (rx_reset_req[i]) begin
                    rx_ph[i] = P_ANA; rx_age[i] = 0;
                end else if ((rx_ph[i] == P_DIG || rx_ph[i] == P_RDY) && !ltd_seen) begin
                    rx_ph[i] = P_LOCK; rx_age[i] = 0;
                    if (relocks[i] < 255) relocks[i]++;
                end else if (hb_fire) begin
                    rx_ph[i] = P_ANA; rx_age[i] = 0;
                    if (relocks[i] < 255) relocks[i]++;
                end else begin
                    case (rx_ph[i])
                        P_ANA: begin rx_age[i]++; if (rx_age[i] == TA) begin rx_ph[i] = P_CAL; rx_age[i] = 0; end end
                        P_CAL: if (!rx_cal_busy[i]) begin rx_ph[i] = P_LOCK; rx_age[i] = 0; end
                        P_LOCK: begin
                            rx_age[i] = ltd_seen ? rx_age[i] + 1 : 0;
                            if (rx_age[i] == TL) begin rx_ph[i] = P_DIG; rx_age[i] = 0; end
                        end
                        P_DIG: begin rx_age[i]++; if (rx_age[i] == TD) begin rx_ph[i] = P_RDY; rx_age[i] = 0; end end
                        default: ;
                    endcase
                end
                hb_run[i] = run_nxt;
            end
        end
        for (int i = 0; i < NCH; i++) exp_relock[8*i +: 8] = relocks[i][7:0];
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("tx_analogreset", tx_analogreset, exp_tx_ana);
            check("tx_digitalreset", tx_digitalreset, exp_tx_dig);
            check("tx_ready", tx_ready, exp_tx_rdy);
            check("rx_analogreset", rx_analogreset, exp_rx_ana);
            check("rx_digitalreset", rx_digitalreset, exp_rx_dig);
            check("rx_ready", rx_ready, exp_rx_rdy);
            check("relock_cnt", relock_cnt, exp_relock);
        end
    end

    task automatic wait_rx_ready(input int lane);
        int n;
        n = 0;
        while (rx_ready[lane] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("rx_ready_wait", rx_ready[lane], 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rise0, rise1, base;
        reconfig_reset_n = 1'b0; pll_locked = 1'b1;
        tx_cal_busy = '0; rx_cal_busy = '0; rx_is_lockedtodata = '1;
        rx_enh_highber = '0; rx_reset_req = '0;

        // Power-up
        repeat (5) tick();
        check("reset_tx_ana", tx_analogreset, 2'b11);
        check("reset_rx_dig", rx_digitalreset, 2'b11);
        check("reset_tx_ready", tx_ready, 1'b0);
        check("reset_relock", relock_cnt, 16'h0);
        reconfig_reset_n = 1'b1;
        repeat (4) tick();
        check("pwr_tx_ana_c4", tx_analogreset, 2'b11);
        tick();
        check("pwr_tx_ana_c5", tx_analogreset, 2'b00);
        repeat (5) tick();
        check("pwr_tx_ready_c10", tx_ready, 1'b0);
        tick();
        check("pwr_tx_ready_c11", tx_ready, 1'b1);
        repeat (5) tick();
        check("pwr_rx_ready_c16", rx_ready, 2'b00);
        tick();
        check("pwr_rx_ready_c17", rx_ready, 2'b11);
        check("pwr_relock", relock_cnt, 16'h0);

        // Cal hold
        reconfig_reset_n = 1'b0; tx_cal_busy = 2'b10;
        tick(); tick();
        reconfig_reset_n = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check("cal_tx_ready_low", tx_ready, 1'b0);
        end
        tx_cal_busy = '0;
        repeat (4) tick();
        check("cal_tx_dig_held", tx_digitalreset, 2'b11);
        tick();
        check("cal_tx_dig_rel", tx_digitalreset, 2'b00);
        check("cal_tx_ready", tx_ready, 1'b1);

        // LTD glitch on lane 0 at count 6
        wait_rx_ready(0); wait_rx_ready(1);
        rx_reset_req = 2'b11;
        tick();
        rx_reset_req = '0;
        repeat (9) tick();
        rx_is_lockedtodata[0] = 1'b0;
        tick();
        rx_is_lockedtodata[0] = 1'b1;
        rise0 = -1; rise1 = -1;
        for (int t = 11; t <= 60; t++) begin
            tick();
            if (rise0 < 0 && rx_ready[0]) rise0 = t;
            if (rise1 < 0 && rx_ready[1]) rise1 = t;
        end
        check("glitch_lane1_rise", rise1, 17);
        check("glitch_delay", rise0 - rise1, 7);

        // Relock on lane 1
        rx_is_lockedtodata[1] = 1'b0;
        tick();
        rx_is_lockedtodata[1] = 1'b1;
        tick(); tick();
        check("relock_ready_before", rx_ready[1], 1'b1);
        tick();
        check("relock_dig", rx_digitalreset[1], 1'b1);
        check("relock_ready", rx_ready[1], 1'b0);
        check("relock_cnt1", relock_cnt[15:8], 8'd1);
        check("relock_lane0", rx_ready[0], 1'b1);
        tick();
        for (int k = 0; k < 299; k++) begin
            wait_rx_ready(1);
            rx_is_lockedtodata[1] = 1'b0;
            tick();
            rx_is_lockedtodata[1] = 1'b1;
            repeat (4) tick();
        end
        check("relock_sat", relock_cnt[15:8], 8'd255);
        check("relock_lane0_cnt", relock_cnt[7:0], 8'd0);

        // Soft reset beats relock on lane 0
        wait_rx_ready(0);
        base = int'(relock_cnt[7:0]);
        rx_is_lockedtodata[0] = 1'b0;
        tick();
        rx_is_lockedtodata[0] = 1'b1;
        tick();
        rx_reset_req = 2'b01;
        tick();
        rx_reset_req = '0;
        tick();
        check("prio_ana", rx_analogreset[0], 1'b1);
        check("prio_relock", relock_cnt[7:0], base[7:0]);

        // High-BER bursts on lane 0: 4 cycles, then 5 cycles
        wait_rx_ready(0);
        base = int'(relock_cnt[7:0]);
        rx_enh_highber[0] = 1'b1;
        repeat (4) tick();
        rx_enh_highber[0] = 1'b0;
        repeat (8) tick();
        check("hb4_ready", rx_ready[0], 1'b1);
        check("hb4_relock", relock_cnt[7:0], base[7:0]);
        rx_enh_highber[0] = 1'b1;
        repeat (5) tick();
        rx_enh_highber[0] = 1'b0;
        repeat (3) tick();
`ifdef ETH_PHY_RSTSEQ_HIBER_RELOCK_EN
        check("hb5_ana", rx_analogreset[0], 1'b1);
        check("hb5_relock", relock_cnt[7:0], 8'(base + 1));
`else
        check("hb5_ana", rx_analogreset[0], 1'b0);
        check("hb5_relock", relock_cnt[7:0], base[7:0]);
`endif

        // Randomized stimulus
        for (int c = 0; c < 4000; c++) begin
            reconfig_reset_n = ($urandom_range(0, 999) != 0);
            pll_locked = pll_locked ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
            for (int unsigned i = 0; i < NCH; i++) begin
                tx_cal_busy[i] = tx_cal_busy[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 399) == 0);
                rx_cal_busy[i] = rx_cal_busy[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) == 0);
                rx_is_lockedtodata[i] = rx_is_lockedtodata[i] ? ($urandom_range(0, 119) != 0)
                                                              : ($urandom_range(0, 2) == 0);
                rx_enh_highber[i] = rx_enh_highber[i] ? ($urandom_range(0, 5) != 0)
                                                      : ($urandom_range(0, 59) == 0);
                rx_reset_req[i] = ($urandom_range(0, 299) == 0);
            end
            tick();
        end
        reconfig_reset_n = 1'b1; rx_reset_req = '0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_phy_reset_seq.md
# eth_phy_reset_seq

Parametrised reset sequencer for NUM_CH 10GBASE-R PHY channels that share one TX serial clock PLL. It drives the analog and digital reset inputs of every channel in the calibrated order. Each RX lane is sequenced independently and is re-sequenced automatically after loss of CDR lock. It sits between the management/reconfig clock domain and the PHY instances, and reports per-lane readiness to the MAC.

## Interface
- NUM_CH, 4: number of PHY channels (1..16)
- T_ANALOG, 70: cycles an analog reset is held
- T_DIGITAL, 20: cycles a digital reset is held after its preconditions are met
- T_LTD, 4000: cycles rx_is_lockedtodata must stay high before digital release
- T_HIBER, 1000: consecutive rx_enh_highber cycles that trigger a relock (macro only)
- reconfig_clk  in  1  sole clock
- reconfig_reset_n  in  1  synchronous, active-low reset
- pll_locked  in  1  shared TX PLL lock (asynchronous input; 2-flop synchronised internally)
- tx_cal_busy  in  NUM_CH  per-channel TX calibration busy
- rx_cal_busy  in  NUM_CH  per-channel RX calibration busy
- rx_is_lockedtodata  in  NUM_CH  CDR lock (2-flop synchronised internally)
- rx_enh_highber  in  NUM_CH  high-BER flag (2-flop synchronised internally)
- rx_reset_req  in  NUM_CH  per-lane soft RX reset request, one-cycle pulse
- tx_analogreset, tx_digitalreset  out  NUM_CH  TX resets, all bits identical
- rx_analogreset, rx_digitalreset  out  NUM_CH  per-lane RX resets
- tx_ready  out  1  all TX channels out of reset
- rx_ready  out  NUM_CH  per-lane RX out of reset
- relock_cnt  out  8*NUM_CH  per-lane saturating count of automatic RX relocks; lane i is in [8i+7:8i]

## Operation
- TX FSM (one instance for all channels):
  - TX_ARST: both TX resets = 1; stays T_ANALOG cycles, then goes to TX_WAIT.
  - TX_WAIT: analog reset = 0, digital reset = 1; leaves when synchronised pll_locked = 1 and every tx_cal_busy bit = 0, then goes to TX_DRST.
  - TX_DRST: digital reset = 1; stays T_DIGITAL cycles, then goes to TX_READY.
  - TX_READY: both resets = 0, tx_ready = 1.
  - Loss of pll_locked in TX_DRST or TX_READY returns the FSM to TX_ARST.
- RX FSM (one instance per lane i, independent of TX):
  - RX_ARST: both RX resets = 1; stays T_ANALOG cycles.
  - RX_WAIT_CAL: analog reset = 0; waits for rx_cal_busy[i] = 0.
  - RX_WAIT_LTD: needs rx_is_lockedtodata[i] high for T_LTD consecutive cycles; any low sample restarts the count at 0.
  - RX_DRST: digital reset = 1; stays T_DIGITAL cycles.
  - RX_READY: both resets = 0, rx_ready[i] = 1.
- RX relock: lockedtodata low in RX_DRST or RX_READY sends the lane to RX_WAIT_LTD with digital reset re-asserted, and increments relock_cnt[i]. The count saturates at 255.
- Soft reset: rx_reset_req[i] in any state sends the lane to RX_ARST and clears its counter. relock_cnt is not incremented.
- Simultaneous events on one lane: rx_reset_req has priority over relock. Relock has priority over a counter expiry in the same cycle.
- Counters are $clog2(max(T_*)+1) bits wide and count 0..T−1. The FSM leaves the state on the cycle the count equals T−1.

## Timing
- Reset values: all four reset output buses all-ones; tx_ready = 0; rx_ready = 0; relock_cnt = 0; FSMs in TX_ARST / RX_ARST with counters at 0.
- All outputs are registered and decoded from the state register; no combinational path runs from input to output.
- Input-condition latency: a state change takes effect on outputs 1 cycle after the qualifying sample. For synchronised inputs, add 2 cycles.
- Reset asserted mid-sequence: outputs return to reset values on the next edge, regardless of state.
- Minimum TX sequence from reset release (conditions already met): T_ANALOG + 3 + T_DIGITAL + 1 cycles to tx_ready.

## Configuration
- ETH_PHY_RSTSEQ_HIBER_RELOCK_EN defined:
  - Synchronised rx_enh_highber[i] high for T_HIBER consecutive cycles while in RX_READY forces lane i to RX_ARST.
  - relock_cnt[i] is incremented.
  - The high-BER counter clears whenever the flag drops.
- Not defined: rx_enh_highber is ignored (synchroniser and counter are not built), and relock happens only on lockedtodata loss.

## Test plan
- Bench parameters for every scenario: NUM_CH=2, T_ANALOG=4, T_DIGITAL=3, T_LTD=8, T_HIBER=5.
- Power-up: reset_n low for 5 cycles, then high; pll_locked, lockedtodata high; cal_busy low. Required: tx_analogreset falls after 4 cycles, tx_ready rises at cycle 11, rx_ready rises on both lanes; relock_cnt = 0.
- Cal hold: tx_cal_busy[1] held high 20 cycles. Required: tx_digitalreset stays 1 until 3 cycles after cal_busy falls plus sync latency; tx_ready = 0 throughout.
- LTD glitch: lane 0 lockedtodata low for 1 cycle at count 6 of RX_WAIT_LTD. Required: the count restarts, and lane 0 rx_ready is delayed by 7 cycles relative to lane 1.
- Relock: lane 1 lockedtodata drops while in RX_READY. Required: rx_digitalreset[1] = 1 and rx_ready[1] = 0 within 3 cycles; relock_cnt[15:8] = 1; lane 0 is unaffected. Repeat 300 times: relock_cnt[15:8] saturates at 255.
- Priority: rx_reset_req[0] and a lockedtodata drop on lane 0 in the same cycle. Required: lane 0 goes to RX_ARST and relock_cnt[7:0] is unchanged.
- Macro on: highber[0] high for 5 cycles in RX_READY. Required: rx_analogreset[0] = 1 and relock_cnt[7:0] increments. With highber high for only 4 cycles, no action. Macro off: no action in either case.
